// File: rtl/fft8_bitrev_loader.sv
// Ping-pong input buffer for the 8-point FFT: collects 8-sample frames and drains them as bit-reversed operand pairs.
// Optional start-of-frame checking is enabled with the FFT8_SOF_CHECK_EN macro.
module fft8_bitrev_loader #(
    parameter int SIZE_DATA = 32,
    parameter int N_POINT   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
`ifdef FFT8_SOF_CHECK_EN
    input  logic                 i_sof,
    output logic                 o_sof_err,
`endif
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_data_0,
    output logic [SIZE_DATA-1:0] o_data_1,
    output logic [1:0]           o_pair_idx,
    output logic                 o_last,
    input  logic                 i_ready
);

    localparam int W_CNT = $clog2(N_POINT);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [SIZE_DATA-1:0] r_mem [2][N_POINT];
    logic [1:0]           r_full;
    logic                 r_wr_bank;
    logic [W_CNT-1:0]     r_wr_cnt;
    logic                 r_rd_bank;
    logic [0:0]           r_state;
    logic                 r_valid;
    logic [SIZE_DATA-1:0] r_data_0;
    logic [SIZE_DATA-1:0] r_data_1;
    logic [1:0]           r_pair_idx;
    logic                 r_last;

    logic                 w_accept;
    logic                 w_restart;
    logic                 w_wr_done;
    logic [W_CNT-1:0]     w_wr_slot;
    logic                 w_xfer;
    logic                 w_xfer_last;
    logic [1:0]           w_full_nxt;
    logic                 w_ld;
    logic                 w_ld_bank;
    logic [1:0]           w_ld_pair;

    function automatic logic [2:0] f_bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    assign o_ready  = !r_full[r_wr_bank];
    assign w_accept = i_valid && o_ready;

`ifdef FFT8_SOF_CHECK_EN
    logic r_sof_err;
    // A start marker mid-frame abandons the partial frame and restarts at slot 0.
    assign w_restart = w_accept && i_sof && (r_wr_cnt != '0);
    assign o_sof_err = r_sof_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sof_err <= 1'b0;
        else          r_sof_err <= w_restart;
    end
`else
    assign w_restart = 1'b0;
`endif

    assign w_wr_slot   = w_restart ? '0 : r_wr_cnt;
    assign w_wr_done   = w_accept && !w_restart && (r_wr_cnt == W_CNT'(N_POINT - 1));
    assign w_xfer      = r_valid && i_ready;
    assign w_xfer_last = w_xfer && r_last;

    always_comb begin
        w_full_nxt = r_full;
        if (w_xfer_last) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_wr_done)   w_full_nxt[r_wr_bank] = 1'b1;
    end

    // Decide whether a pair loads this edge, and from which bank/pair.
    always_comb begin
        w_ld      = 1'b0;
        w_ld_bank = r_rd_bank;
        w_ld_pair = 2'd0;
        if (r_state == S_IDLE) begin
            w_ld = r_full[r_rd_bank];
        end else if (w_xfer) begin
            if (!r_last) begin
                w_ld      = 1'b1;
                w_ld_pair = r_pair_idx + 2'd1;
            end else if (r_full[~r_rd_bank]) begin
                w_ld      = 1'b1;
                w_ld_bank = ~r_rd_bank;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) r_mem[r_wr_bank][w_wr_slot] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_accept) begin
                if (w_restart) begin
                    r_wr_cnt <= W_CNT'(1);
                end else if (w_wr_done) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_xfer_last) r_rd_bank <= ~r_rd_bank;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_data_0   <= '0;
            r_data_1   <= '0;
            r_pair_idx <= 2'd0;
            r_last     <= 1'b0;
        end else if (w_ld) begin
            r_state    <= S_DRAIN;
            r_valid    <= 1'b1;
            r_data_0   <= r_mem[w_ld_bank][f_bitrev3({w_ld_pair, 1'b0})];
            r_data_1   <= r_mem[w_ld_bank][f_bitrev3({w_ld_pair, 1'b1})];
            r_pair_idx <= w_ld_pair;
            r_last     <= (w_ld_pair == 2'd3);
        end else if (w_xfer) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_pair_idx <= 2'd0;
            r_last     <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_data_0   = r_data_0;
    assign o_data_1   = r_data_1;
    assign o_pair_idx = r_pair_idx;
    assign o_last     = r_last;

endmodule

// File: tb/tb_fft8_bitrev_loader.sv
// Self-checking bench for fft8_bitrev_loader: frame-level reference model with randomized stimulus.
`timescale 1ns/1ps
module tb_fft8_bitrev_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_data;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_data_0;
    logic [31:0] o_data_1;
    logic [1:0]  o_pair_idx;
    logic        o_last;
    logic        i_ready;
`ifdef FFT8_SOF_CHECK_EN
    logic        i_sof;
    logic        o_sof_err;
`endif

    always #5 i_clk = ~i_clk;

    fft8_bitrev_loader #(.SIZE_DATA(32), .N_POINT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
`ifdef FFT8_SOF_CHECK_EN
        .i_sof(i_sof), .o_sof_err(o_sof_err),
`endif
        .o_ready(o_ready), .o_valid(o_valid), .o_data_0(o_data_0), .o_data_1(o_data_1),
        .o_pair_idx(o_pair_idx), .o_last(o_last), .i_ready(i_ready)
    );

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  idx;
        logic        last;
    } pair_t;

    pair_t       exp_q[$];
    pair_t       obs_q[$];
    logic [31:0] part[$];
    bit          rdy_obs[$];
    bit          rdy_exp[$];
    int          nfull;
    int          ntr;
    int          errors = 0;
    int          checks = 0;
    logic        tb_sof = 1'b0;

    logic [31:0] e0 [4] = '{32'h10, 32'h12, 32'h11, 32'h13};
    logic [31:0] e1 [4] = '{32'h14, 32'h16, 32'h15, 32'h17};

    function automatic int brev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    task automatic model_reset();
        part.delete(); exp_q.delete(); obs_q.delete();
        rdy_obs.delete(); rdy_exp.delete();
        nfull = 0; ntr = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
`ifdef FFT8_SOF_CHECK_EN
        i_sof = 1'b0;
`endif
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus; records observations and advances the frame model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic rdy);
        bit    acc, xfer;
        pair_t p;
        i_valid = v; i_data = d; i_ready = rdy;
`ifdef FFT8_SOF_CHECK_EN
        i_sof = tb_sof;
`endif
        #1;
        rdy_obs.push_back(o_ready);
        rdy_exp.push_back(nfull < 2);
        acc  = v && (nfull < 2);
        xfer = o_valid && rdy;
        if (xfer) begin
            p.d0 = o_data_0; p.d1 = o_data_1; p.idx = o_pair_idx; p.last = o_last;
            obs_q.push_back(p);
        end
        @(posedge i_clk);
        if (xfer) begin
            ntr++;
            if (ntr % 4 == 0) nfull--;
        end
        if (acc) begin
            if (tb_sof && part.size() != 0) part.delete();
            part.push_back(d);
            if (part.size() == 8) begin
                for (int q = 0; q < 4; q++) begin
                    p.d0 = part[brev(2*q)]; p.d1 = part[brev(2*q+1)];
                    p.idx = 2'(q); p.last = (q == 3);
                    exp_q.push_back(p);
                end
                part.delete();
                nfull++;
            end
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
`ifdef FFT8_SOF_CHECK_EN
        i_sof = 1'b0;
`endif
        @(negedge i_clk);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_data_0 !== 32'h0) begin errors++; $display("FAIL reset_d0: got %h want 0", o_data_0); end
        checks++; if (o_data_1 !== 32'h0) begin errors++; $display("FAIL reset_d1: got %h want 0", o_data_1); end
        checks++; if (o_pair_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", o_pair_idx); end
        checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", o_last); end
        i_rst_n = 1'b1;
        model_reset();
        @(negedge i_clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h10 + i, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_latency: o_valid %b want 0 right after 8th accept", o_valid); end
        for (int p = 0; p < 4; p++) begin
            cycle(1'b0, '0, 1'b1);
            checks++;
            if (o_valid !== 1'b1 || o_data_0 !== e0[p] || o_data_1 !== e1[p] ||
                o_pair_idx !== 2'(p) || o_last !== (p == 3)) begin
                errors++;
                $display("FAIL single_pair%0d: got v=%b %h %h idx=%0d last=%b want v=1 %h %h idx=%0d last=%b",
                         p, o_valid, o_data_0, o_data_1, o_pair_idx, o_last, e0[p], e1[p], p, (p == 3));
            end
        end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_end: o_valid %b want 0", o_valid); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_q%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_streaming();
        int zeros = 0;
        do_reset();
        for (int i = 0; i < 24; i++) cycle(1'b1, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 24; i++) if (rdy_obs[i] == 1'b0) zeros++;
        checks++; if (zeros !== 0) begin errors++; $display("FAIL stream_ready: o_ready low %0d cycles want 0", zeros); end
        checks++; if (obs_q.size() !== 12 || exp_q.size() !== 12) begin errors++; $display("FAIL stream_count: got %0d want %0d (12)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_q%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] h0, h1;
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0);
        checks++; if (rdy_obs[15] !== 1'b1) begin errors++; $display("FAIL bp_ready15: got %b want 1", rdy_obs[15]); end
        checks++; if (rdy_obs[16] !== 1'b0) begin errors++; $display("FAIL bp_ready16: got %b want 0", rdy_obs[16]); end
        for (int i = 0; i < rdy_obs.size(); i++) begin
            checks++; if (rdy_obs[i] !== rdy_exp[i]) begin errors++; $display("FAIL bp_ready_c%0d: got %b want %b", i, rdy_obs[i], rdy_exp[i]); end
        end
        h0 = o_data_0; h1 = o_data_1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0);
            checks++;
            if (o_valid !== 1'b1 || o_data_0 !== h0 || o_data_1 !== h1) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b %h %h want v=1 %h %h", i, o_valid, o_data_0, o_data_1, h0, h1);
            end
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_pre: got %b want 0 before pair 3 transfer", o_ready); end
        cycle(1'b0, '0, 1'b1);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_post: got %b want 1 after pair 3 transfer", o_ready); end
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_q%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gapped();
        int  k = 0;
        logic v;
        do_reset();
        for (int c = 0; c < 60 && k < 8; c++) begin
            v = (c % 2 == 0) ? 1'b1 : 1'($urandom % 2);
            cycle(v, 32'h10 + k, 1'b1);
            if (v) k++;
            if (k < 8) begin
                checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL gap_spurious: o_valid %b want 0 at c%0d", o_valid, c); end
            end
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL gap_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].d0 !== e0[i] || obs_q[i].d1 !== e1[i]) begin
                errors++; $display("FAIL gap_pair%0d: got %h %h want %h %h", i, obs_q[i].d0, obs_q[i].d1, e0[i], e1[i]);
            end
        end
    endtask

    task automatic test_random();
        int  k = 0;
        logic v;
        do_reset();
        for (int c = 0; c < 400 && k < 24; c++) begin
            v = 1'($urandom % 2);
            if (v && nfull < 2) k++;
            cycle(v, $urandom, 1'($urandom % 4 != 0));
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'($urandom % 2));
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1);
        checks++; if (k !== 24) begin errors++; $display("FAIL rand_accepts: got %0d want 24 within budget", k); end
        for (int i = 0; i < rdy_obs.size(); i++) begin
            checks++; if (rdy_obs[i] !== rdy_exp[i]) begin errors++; $display("FAIL rand_ready_c%0d: got %b want %b", i, rdy_obs[i], rdy_exp[i]); end
        end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_q%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b1);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data_0 !== 32'h0 || o_data_1 !== 32'h0 || o_pair_idx !== 2'd0 || o_last !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got v=%b %h %h idx=%0d last=%b want all 0",
                               o_valid, o_data_0, o_data_1, o_pair_idx, o_last);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h20 + i, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL midrst_count: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            checks++;
            if (obs_q[i].d0 !== e0[i] + 32'h10 || obs_q[i].d1 !== e1[i] + 32'h10) begin
                errors++; $display("FAIL midrst_pair%0d: got %h %h want %h %h", i, obs_q[i].d0, obs_q[i].d1, e0[i] + 32'h10, e1[i] + 32'h10);
            end
        end
    endtask

`ifdef FFT8_SOF_CHECK_EN
    task automatic test_sof();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1 + i, 1'b1);
        tb_sof = 1'b1;
        cycle(1'b1, 32'hA0, 1'b1);
        tb_sof = 1'b0;
        checks++; if (o_sof_err !== 1'b1) begin errors++; $display("FAIL sof_pulse: got %b want 1", o_sof_err); end
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, 32'hA0 + i, 1'b1);
            if (o_sof_err === 1'b1) pulses++;
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (o_sof_err === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL sof_extra: %0d extra pulses want 0", pulses); end
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL sof_count: got %0d want 4", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0].d0 !== 32'hA0 || obs_q[0].d1 !== 32'hA4) begin
                errors++; $display("FAIL sof_pair0: got %h %h want a0 a4", obs_q[0].d0, obs_q[0].d1);
            end
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_q%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_streaming();
        test_backpressure();
        test_gapped();
        test_random();
        test_reset_mid();
`ifdef FFT8_SOF_CHECK_EN
        test_sof();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
